// File: rtl/usb_desc_pkg.sv
// Shared constants for the EP0 descriptor responder: descriptor types,
// string indices and FSM state codes.
package usb_desc_pkg;

   localparam logic [7:0] DT_DEV    = 8'h01;
   localparam logic [7:0] DT_CFG    = 8'h02;
   localparam logic [7:0] DT_STR    = 8'h03;
   localparam logic [7:0] DT_QUAL   = 8'h06;
   localparam logic [7:0] DT_OSCFG  = 8'h07;
   localparam logic [7:0] DT_BOS    = 8'h0F;
   localparam logic [7:0] DT_HIDRPT = 8'h22;

   localparam logic [7:0] STR_LANG    = 8'd0;
   localparam logic [7:0] STR_VENDOR  = 8'd1;
   localparam logic [7:0] STR_PRODUCT = 8'd2;
   localparam logic [7:0] STR_SERIAL  = 8'd3;

   // The language-ID table is always a single 16-bit LANGID.
   localparam int STRLANG_LEN = 4;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_WAIT_IN  = 3'd1;
   localparam logic [2:0] S_SEND     = 3'd2;
   localparam logic [2:0] S_WAIT_ACK = 3'd3;
   localparam logic [2:0] S_STALL    = 3'd4;

endpackage

// File: rtl/usb_desc_sel.sv
// Combinational descriptor lookup: request type/index and link speed to the
// ROM address and length of the matching descriptor, plus a validity flag.
module usb_desc_sel
   import usb_desc_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic [7:0]        desc_type,
   input  logic [7:0]        desc_index,
   input  logic              high_speed,
   input  logic              have_strings,
   input  logic [ADDR_W-1:0] dev_addr,
   input  logic [ADDR_W-1:0] dev_len,
   input  logic [ADDR_W-1:0] qual_addr,
   input  logic [ADDR_W-1:0] qual_len,
   input  logic [ADDR_W-1:0] fscfg_addr,
   input  logic [ADDR_W-1:0] fscfg_len,
   input  logic [ADDR_W-1:0] hscfg_addr,
   input  logic [ADDR_W-1:0] hscfg_len,
   input  logic [ADDR_W-1:0] oscfg_addr,
   input  logic [ADDR_W-1:0] hidrpt_addr,
   input  logic [ADDR_W-1:0] hidrpt_len,
   input  logic [ADDR_W-1:0] bos_addr,
   input  logic [ADDR_W-1:0] bos_len,
   input  logic [ADDR_W-1:0] strlang_addr,
   input  logic [ADDR_W-1:0] strvendor_addr,
   input  logic [ADDR_W-1:0] strvendor_len,
   input  logic [ADDR_W-1:0] strproduct_addr,
   input  logic [ADDR_W-1:0] strproduct_len,
   input  logic [ADDR_W-1:0] strserial_addr,
   input  logic [ADDR_W-1:0] strserial_len,
   output logic [ADDR_W-1:0] sel_addr,
   output logic [ADDR_W-1:0] sel_len,
   output logic              sel_ok
);

   logic known;

   always_comb begin
      sel_addr = '0;
      sel_len  = '0;
      known    = 1'b1;
      case (desc_type)
         DT_DEV:    begin sel_addr = dev_addr;    sel_len = dev_len;    end
         DT_QUAL:   begin sel_addr = qual_addr;   sel_len = qual_len;   end
         DT_CFG: begin
            sel_addr = high_speed ? hscfg_addr : fscfg_addr;
            sel_len  = high_speed ? hscfg_len  : fscfg_len;
         end
         // Other-speed config reuses the opposite speed's length; type byte is patched on the fly.
         DT_OSCFG: begin
            sel_addr = oscfg_addr;
            sel_len  = high_speed ? fscfg_len : hscfg_len;
         end
         DT_BOS:    begin sel_addr = bos_addr;    sel_len = bos_len;    end
         DT_HIDRPT: begin sel_addr = hidrpt_addr; sel_len = hidrpt_len; end
         DT_STR: begin
            if (!have_strings) known = 1'b0;
            case (desc_index)
               STR_LANG:    begin sel_addr = strlang_addr;    sel_len = ADDR_W'(STRLANG_LEN); end
               STR_VENDOR:  begin sel_addr = strvendor_addr;  sel_len = strvendor_len;  end
               STR_PRODUCT: begin sel_addr = strproduct_addr; sel_len = strproduct_len; end
               STR_SERIAL:  begin sel_addr = strserial_addr;  sel_len = strserial_len;  end
               default:     known = 1'b0;
            endcase
         end
         default: known = 1'b0;
      endcase
      sel_ok = known && (sel_len != '0);
   end

endmodule

// File: rtl/usb_desc_tx.sv
// EP0 control-IN responder: decodes GET_DESCRIPTOR, then streams the descriptor
// from ROM as MAX_PKT-sized IN packets with retry, ZLP and STALL handling.
//
//   state    | meaning
//   IDLE     | no transfer in progress
//   WAIT_IN  | data owed, waiting for the host's IN token
//   SEND     | streaming the current packet to the TX engine
//   WAIT_ACK | packet sent, waiting for ACK (or an IN retry)
//   STALL    | request unsupported; IN answered with STALL
module usb_desc_tx
   import usb_desc_pkg::*;
#(
   parameter int MAX_PKT = 64,
   parameter int ADDR_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              setup_valid_i,
   input  logic [7:0]        setup_type_i,
   input  logic [7:0]        setup_index_i,
   input  logic [15:0]       setup_len_i,
   input  logic              high_speed_i,
   input  logic              abort_i,
   input  logic              in_tok_i,
   input  logic              in_ack_i,
   output logic              tx_valid_o,
   output logic [7:0]        tx_data_o,
   output logic              tx_last_o,
   input  logic              tx_ready_i,
   output logic              tx_zlp_o,
   output logic              stall_o,
   output logic              done_o,
   output logic [ADDR_W-1:0] descrom_raddr_o,
   input  logic [7:0]        descrom_rdata_i,
   input  logic [ADDR_W-1:0] desc_dev_addr_i,
   input  logic [ADDR_W-1:0] desc_dev_len_i,
   input  logic [ADDR_W-1:0] desc_qual_addr_i,
   input  logic [ADDR_W-1:0] desc_qual_len_i,
   input  logic [ADDR_W-1:0] desc_fscfg_addr_i,
   input  logic [ADDR_W-1:0] desc_fscfg_len_i,
   input  logic [ADDR_W-1:0] desc_hscfg_addr_i,
   input  logic [ADDR_W-1:0] desc_hscfg_len_i,
   input  logic [ADDR_W-1:0] desc_oscfg_addr_i,
   input  logic [ADDR_W-1:0] desc_hidrpt_addr_i,
   input  logic [ADDR_W-1:0] desc_hidrpt_len_i,
   input  logic [ADDR_W-1:0] desc_bos_addr_i,
   input  logic [ADDR_W-1:0] desc_bos_len_i,
   input  logic [ADDR_W-1:0] desc_strlang_addr_i,
   input  logic [ADDR_W-1:0] desc_strvendor_addr_i,
   input  logic [ADDR_W-1:0] desc_strvendor_len_i,
   input  logic [ADDR_W-1:0] desc_strproduct_addr_i,
   input  logic [ADDR_W-1:0] desc_strproduct_len_i,
   input  logic [ADDR_W-1:0] desc_strserial_addr_i,
   input  logic [ADDR_W-1:0] desc_strserial_len_i,
   input  logic              desc_have_strings_i
);

   localparam int                PKT_W     = $clog2(MAX_PKT);
   localparam logic [ADDR_W-1:0] MAX_PKT_W = ADDR_W'(MAX_PKT);
   localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

   logic [2:0]        state;
   logic [ADDR_W-1:0] ptr, pkt_start, remaining, pkt_len, pkt_left, patch_addr;
   logic              zlp_owed, patch_en;
   logic [ADDR_W-1:0] sel_addr, sel_len, wlen, total, next_pkt_len, rem_after;
   logic              sel_ok, send;

   usb_desc_sel #(.ADDR_W(ADDR_W)) u_sel (
      .desc_type       (setup_type_i),
      .desc_index      (setup_index_i),
      .high_speed      (high_speed_i),
      .have_strings    (desc_have_strings_i),
      .dev_addr        (desc_dev_addr_i),
      .dev_len         (desc_dev_len_i),
      .qual_addr       (desc_qual_addr_i),
      .qual_len        (desc_qual_len_i),
      .fscfg_addr      (desc_fscfg_addr_i),
      .fscfg_len       (desc_fscfg_len_i),
      .hscfg_addr      (desc_hscfg_addr_i),
      .hscfg_len       (desc_hscfg_len_i),
      .oscfg_addr      (desc_oscfg_addr_i),
      .hidrpt_addr     (desc_hidrpt_addr_i),
      .hidrpt_len      (desc_hidrpt_len_i),
      .bos_addr        (desc_bos_addr_i),
      .bos_len         (desc_bos_len_i),
      .strlang_addr    (desc_strlang_addr_i),
      .strvendor_addr  (desc_strvendor_addr_i),
      .strvendor_len   (desc_strvendor_len_i),
      .strproduct_addr (desc_strproduct_addr_i),
      .strproduct_len  (desc_strproduct_len_i),
      .strserial_addr  (desc_strserial_addr_i),
      .strserial_len   (desc_strserial_len_i),
      .sel_addr        (sel_addr),
      .sel_len         (sel_len),
      .sel_ok          (sel_ok)
   );

   assign wlen         = ADDR_W'(setup_len_i);
   assign total        = (sel_len < wlen) ? sel_len : wlen;
   assign next_pkt_len = (remaining < MAX_PKT_W) ? remaining : MAX_PKT_W;
   assign rem_after    = remaining - pkt_len;
   assign send         = (state == S_SEND);

   assign tx_valid_o      = send;
   assign tx_last_o       = send && (pkt_left == ONE);
   assign tx_data_o       = !send ? 8'h00 :
                            (patch_en && (ptr == patch_addr)) ? DT_OSCFG : descrom_rdata_i;
   assign stall_o         = (state == S_STALL);
   assign descrom_raddr_o = ptr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         ptr        <= '0;
         pkt_start  <= '0;
         remaining  <= '0;
         pkt_len    <= '0;
         pkt_left   <= '0;
         patch_addr <= '0;
         patch_en   <= 1'b0;
         zlp_owed   <= 1'b0;
         tx_zlp_o   <= 1'b0;
         done_o     <= 1'b0;
      end else begin
         tx_zlp_o <= 1'b0;
         done_o   <= 1'b0;
         if (abort_i) begin
            state <= S_IDLE;
         end else if (setup_valid_i) begin
            ptr        <= sel_addr;
            pkt_start  <= sel_addr;
            remaining  <= total;
            pkt_len    <= '0;
            pkt_left   <= '0;
            zlp_owed   <= (total[PKT_W-1:0] == '0) && (total < wlen);
            patch_en   <= (setup_type_i == DT_OSCFG);
            patch_addr <= sel_addr + ONE;
            if (!sel_ok) begin
               state <= S_STALL;
            end else if (wlen == '0) begin
               state  <= S_IDLE;
               done_o <= 1'b1;
            end else begin
               state <= S_WAIT_IN;
            end
         end else begin
            case (state)
               S_WAIT_IN: begin
                  if (in_tok_i) begin
                     pkt_start <= ptr;
                     pkt_len   <= next_pkt_len;
                     pkt_left  <= next_pkt_len;
                     if (next_pkt_len == '0) begin
                        tx_zlp_o <= 1'b1;
                        state    <= S_WAIT_ACK;
                     end else begin
                        state <= S_SEND;
                     end
                  end
               end
               S_SEND: begin
                  if (tx_ready_i) begin
                     ptr      <= ptr + ONE;
                     pkt_left <= pkt_left - ONE;
                     if (pkt_left == ONE) state <= S_WAIT_ACK;
                  end
               end
               S_WAIT_ACK: begin
                  if (in_ack_i) begin
                     remaining <= rem_after;
                     if (pkt_len == '0) zlp_owed <= 1'b0;
                     if ((rem_after == '0) && (!zlp_owed || (pkt_len == '0))) begin
                        state  <= S_IDLE;
                        done_o <= 1'b1;
                     end else begin
                        state <= S_WAIT_IN;
                     end
                  end else if (in_tok_i) begin
                     // Host never saw our packet: rewind and send it again verbatim.
                     ptr      <= pkt_start;
                     pkt_left <= pkt_len;
                     if (pkt_len == '0) tx_zlp_o <= 1'b1;
                     else               state    <= S_SEND;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_usb_desc_tx.sv
// Scoreboard bench for usb_desc_tx: host-side driver with randomized requests,
// retries and back-pressure; monitor checks every accepted byte against a queue.
module tb_usb_desc_tx;

   localparam int MP = 8;

   localparam int DEV_A   = 'h010, DEV_L   = 18;
   localparam int QUAL_A  = 'h040, QUAL_L  = 10;
   localparam int FS_A    = 'h080, FS_L    = 39;
   localparam int HS_A    = 'h100, HS_L    = 46;
   localparam int OS_A    = 'h180;
   localparam int HID_A   = 'h200, HID_L   = 24;
   localparam int BOS_A   = 'h280, BOS_L   = 16;
   localparam int LANG_A  = 'h300;
   localparam int VEND_A  = 'h310, VEND_L  = 26;
   localparam int PROD_A  = 'h340, PROD_L  = 38;
   localparam int SER_A   = 'h380, SER_L   = 0;

   logic        clk = 1'b0;
   logic        rst;
   logic        setup_valid_i, high_speed_i, abort_i, in_tok_i, in_ack_i, tx_ready_i;
   logic [7:0]  setup_type_i, setup_index_i;
   logic [15:0] setup_len_i;
   logic        tx_valid_o, tx_last_o, tx_zlp_o, stall_o, done_o;
   logic [7:0]  tx_data_o, descrom_rdata_i;
   logic [15:0] descrom_raddr_o;
   logic        desc_have_strings_i;

   logic [7:0]  rom [1024];
   logic [8:0]  exp_q [$];
   logic [7:0]  tlist [8];
   int          tests = 0, fails = 0;
   int          zlp_cnt = 0, done_cnt = 0;
   bit          rand_ready = 1'b1;

   always #5 clk = ~clk;
   assign descrom_rdata_i = rom[descrom_raddr_o[9:0]];

   usb_desc_tx #(.MAX_PKT(MP), .ADDR_W(16)) dut (
      .clk(clk), .rst(rst),
      .setup_valid_i(setup_valid_i), .setup_type_i(setup_type_i),
      .setup_index_i(setup_index_i), .setup_len_i(setup_len_i),
      .high_speed_i(high_speed_i), .abort_i(abort_i),
      .in_tok_i(in_tok_i), .in_ack_i(in_ack_i),
      .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_last_o(tx_last_o),
      .tx_ready_i(tx_ready_i), .tx_zlp_o(tx_zlp_o), .stall_o(stall_o), .done_o(done_o),
      .descrom_raddr_o(descrom_raddr_o), .descrom_rdata_i(descrom_rdata_i),
      .desc_dev_addr_i(16'(DEV_A)),       .desc_dev_len_i(16'(DEV_L)),
      .desc_qual_addr_i(16'(QUAL_A)),     .desc_qual_len_i(16'(QUAL_L)),
      .desc_fscfg_addr_i(16'(FS_A)),      .desc_fscfg_len_i(16'(FS_L)),
      .desc_hscfg_addr_i(16'(HS_A)),      .desc_hscfg_len_i(16'(HS_L)),
      .desc_oscfg_addr_i(16'(OS_A)),
      .desc_hidrpt_addr_i(16'(HID_A)),    .desc_hidrpt_len_i(16'(HID_L)),
      .desc_bos_addr_i(16'(BOS_A)),       .desc_bos_len_i(16'(BOS_L)),
      .desc_strlang_addr_i(16'(LANG_A)),
      .desc_strvendor_addr_i(16'(VEND_A)),  .desc_strvendor_len_i(16'(VEND_L)),
      .desc_strproduct_addr_i(16'(PROD_A)), .desc_strproduct_len_i(16'(PROD_L)),
      .desc_strserial_addr_i(16'(SER_A)),   .desc_strserial_len_i(16'(SER_L)),
      .desc_have_strings_i(desc_have_strings_i)
   );

   // Monitor: pops the scoreboard on every accepted byte, counts pulses,
   // and checks data stays put while the TX engine stalls.
   initial begin
      logic [8:0] e;
      logic       hold_v;
      logic [7:0] hold_d;
      hold_v = 1'b0;
      hold_d = 8'h00;
      forever begin
         @(negedge clk);
         if (rst) begin
            hold_v = 1'b0;
         end else begin
            if (tx_zlp_o) zlp_cnt++;
            if (done_o)   done_cnt++;
            if (hold_v && tx_valid_o) begin
               tests++;
               if (tx_data_o !== hold_d) begin
                  fails++;
                  $display("FAIL data_stable got %02h want %02h", tx_data_o, hold_d);
               end
            end
            if (tx_valid_o && tx_ready_i) begin
               tests++;
               if (exp_q.size() == 0) begin
                  fails++;
                  $display("FAIL unexpected_byte got data=%02h last=%0b want no byte", tx_data_o, tx_last_o);
               end else begin
                  e = exp_q.pop_front();
                  if ({tx_last_o, tx_data_o} !== e) begin
                     fails++;
                     $display("FAIL tx_byte got data=%02h last=%0b want data=%02h last=%0b",
                              tx_data_o, tx_last_o, e[7:0], e[8]);
                  end
               end
            end
            hold_v = tx_valid_o && !tx_ready_i;
            hold_d = tx_data_o;
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         tx_ready_i = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s got %0h want %0h", name, got, want);
      end
   endtask

   task automatic pulse_tok();
      in_tok_i = 1'b1;
      tick(1);
      in_tok_i = 1'b0;
   endtask

   task automatic pulse_ack();
      in_ack_i = 1'b1;
      tick(1);
      in_ack_i = 1'b0;
   endtask

   task automatic setup(input logic [7:0] t, input logic [7:0] i, input logic [15:0] wl);
      setup_type_i  = t;
      setup_index_i = i;
      setup_len_i   = wl;
      setup_valid_i = 1'b1;
      tick(1);
      setup_valid_i = 1'b0;
   endtask

   // Reference descriptor table lookup.
   function automatic void lookup(input logic [7:0] t, input logic [7:0] i, input bit hs,
                                  input bit have_str, output int addr, output int len, output bit ok);
      ok = 1'b1; addr = 0; len = 0;
      case (t)
         8'h01: begin addr = DEV_A;  len = DEV_L;  end
         8'h06: begin addr = QUAL_A; len = QUAL_L; end
         8'h02: begin addr = hs ? HS_A : FS_A; len = hs ? HS_L : FS_L; end
         8'h07: begin addr = OS_A;   len = hs ? FS_L : HS_L; end
         8'h0F: begin addr = BOS_A;  len = BOS_L;  end
         8'h22: begin addr = HID_A;  len = HID_L;  end
         8'h03: begin
            if (!have_str || i > 3) ok = 1'b0;
            else if (i == 0) begin addr = LANG_A; len = 4;      end
            else if (i == 1) begin addr = VEND_A; len = VEND_L; end
            else if (i == 2) begin addr = PROD_A; len = PROD_L; end
            else             begin addr = SER_A;  len = SER_L;  end
         end
         default: ok = 1'b0;
      endcase
      if (len == 0) ok = 1'b0;
   endfunction

   task automatic run_xfer(input logic [7:0] t, input logic [7:0] i, input int wl);
      int addr, len, total, sent, plen, tries, z0, d0, wn;
      bit ok, zlp, fin;
      logic [7:0] b;
      lookup(t, i, high_speed_i, desc_have_strings_i, addr, len, ok);
      d0 = done_cnt;
      setup(t, i, 16'(wl));
      if (!ok) begin
         check("stall_set", 32'(stall_o), 1);
         pulse_tok();
         tick(4);
         check("stall_hold", 32'(stall_o), 1);
         return;
      end
      check("stall_clear", 32'(stall_o), 0);
      if (wl == 0) begin
         tick(2);
         check("done_wlen0", done_cnt, d0 + 1);
         return;
      end
      total = (len < wl) ? len : wl;
      zlp   = ((total % MP) == 0) && (total < wl);
      sent  = 0;
      while (sent < total || zlp) begin
         plen  = (total - sent > MP) ? MP : total - sent;
         tries = ($urandom_range(0, 3) == 0) ? 2 : 1;
         for (int r = 0; r < tries; r++) begin
            if (plen > 0) begin
               for (int k = 0; k < plen; k++) begin
                  b = rom[(addr + sent + k) % 1024];
                  if (t == 8'h07 && sent + k == 1) b = 8'h07;
                  exp_q.push_back({(k == plen - 1), b});
               end
               pulse_tok();
               wn = 0;
               while (exp_q.size() != 0 && wn < 300) begin
                  tick(1);
                  wn++;
               end
               check("pkt_drain", exp_q.size(), 0);
               if (exp_q.size() != 0) begin
                  abort_i = 1'b1;
                  tick(1);
                  abort_i = 1'b0;
                  exp_q.delete();
                  return;
               end
               tick(2);
            end else begin
               z0 = zlp_cnt;
               pulse_tok();
               tick(2);
               check("zlp_pulse", zlp_cnt, z0 + 1);
            end
         end
         sent += plen;
         if (plen == 0) zlp = 1'b0;
         d0 = done_cnt;
         pulse_ack();
         tick(2);
         fin = (sent >= total) && !zlp;
         check("done_pulse", done_cnt, fin ? d0 + 1 : d0);
      end
   endtask

   initial begin
      int wl, z0;
      logic [7:0] t, i;
      rst = 1'b1;
      setup_valid_i = 1'b0; setup_type_i = 8'h00; setup_index_i = 8'h00; setup_len_i = 16'h0;
      high_speed_i = 1'b0; abort_i = 1'b0; in_tok_i = 1'b0; in_ack_i = 1'b0; tx_ready_i = 1'b1;
      desc_have_strings_i = 1'b1;
      tlist = '{8'h01, 8'h02, 8'h03, 8'h06, 8'h07, 8'h0F, 8'h22, 8'h05};
      for (int a = 0; a < 1024; a++) rom[a] = 8'($urandom);

      tick(3);
      check("rst_valid", 32'(tx_valid_o), 0);
      check("rst_last",  32'(tx_last_o), 0);
      check("rst_zlp",   32'(tx_zlp_o), 0);
      check("rst_stall", 32'(stall_o), 0);
      check("rst_done",  32'(done_o), 0);
      check("rst_raddr", 32'(descrom_raddr_o), 0);
      check("rst_data",  32'(tx_data_o), 0);
      rst = 1'b0;
      tick(2);

      run_xfer(8'h01, 8'd0, 64);
      run_xfer(8'h02, 8'd0, 255);
      run_xfer(8'h02, 8'd0, 9);
      run_xfer(8'h03, 8'd2, 255);
      run_xfer(8'h03, 8'd0, 255);
      run_xfer(8'h03, 8'd0, 4);
      run_xfer(8'h0F, 8'd0, 255);
      run_xfer(8'h0F, 8'd0, 16);
      run_xfer(8'h22, 8'd0, 24);
      run_xfer(8'h03, 8'd5, 255);
      run_xfer(8'h55, 8'd0, 10);
      run_xfer(8'h03, 8'd3, 10);
      desc_have_strings_i = 1'b0;
      run_xfer(8'h03, 8'd1, 64);
      desc_have_strings_i = 1'b1;
      high_speed_i = 1'b1;
      run_xfer(8'h07, 8'd0, 255);
      run_xfer(8'h02, 8'd0, 255);
      high_speed_i = 1'b0;
      run_xfer(8'h07, 8'd0, 255);
      run_xfer(8'h01, 8'd0, 0);

      // Abort while a packet is streaming.
      rand_ready = 1'b0;
      setup(8'h01, 8'd0, 16'd64);
      for (int k = 0; k < MP; k++) exp_q.push_back({(k == MP - 1), rom[DEV_A + k]});
      pulse_tok();
      tick(2);
      abort_i = 1'b1;
      tick(1);
      abort_i = 1'b0;
      check("abort_valid", 32'(tx_valid_o), 0);
      exp_q.delete();
      z0 = zlp_cnt;
      pulse_tok();
      tick(3);
      check("abort_idle_zlp", zlp_cnt, z0);
      check("abort_idle_stall", 32'(stall_o), 0);

      // Reset while a packet is streaming.
      setup(8'h02, 8'd0, 16'd255);
      for (int k = 0; k < MP; k++) exp_q.push_back({(k == MP - 1), rom[FS_A + k]});
      pulse_tok();
      tick(2);
      rst = 1'b1;
      #1;
      check("rst_mid_valid", 32'(tx_valid_o), 0);
      check("rst_mid_raddr", 32'(descrom_raddr_o), 0);
      exp_q.delete();
      tick(2);
      rst = 1'b0;
      tick(1);
      pulse_tok();
      tick(3);
      check("rst_mid_idle", 32'(tx_valid_o), 0);
      rand_ready = 1'b1;

      for (int n = 0; n < 40; n++) begin
         t = tlist[$urandom_range(0, 7)];
         i = 8'($urandom_range(0, 5));
         high_speed_i = 1'($urandom_range(0, 1));
         desc_have_strings_i = ($urandom_range(0, 7) != 0);
         case ($urandom_range(0, 3))
            0:       wl = $urandom_range(1, 300);
            1:       wl = MP * $urandom_range(1, 6);
            2:       wl = $urandom_range(0, 3);
            default: wl = $urandom_range(1, 64);
         endcase
         run_xfer(t, i, wl);
      end

      tick(3);
      check("final_queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
